// File: rtl/abr_masked_mult_sched_pkg.sv
// Shared types and constants for the masked multiplier scheduler.
package abr_masked_mult_sched_pkg;

  localparam int NUM_REQ_DEF = 2;
  localparam int ID_W = $clog2(NUM_REQ_DEF);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/abr_masked_N_bit_mult_two_share.sv
// Two-share masked multiplier, one registered stage; the fresh random word
// re-masks the cross products so no share ever holds an unmasked product.
module abr_masked_N_bit_mult_two_share #(
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   zeroize,
  input  logic [1:0][WIDTH-1:0]  x_i,
  input  logic [1:0][WIDTH-1:0]  y_i,
  input  logic [WIDTH-1:0]       rnd_i,
  output logic [1:0]             z_o [WIDTH-1:0]
);

  logic [1:0][WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] p00, p01, p10, p11;

  always_comb begin
    p00 = x_i[0] * y_i[0];
    p01 = x_i[0] * y_i[1];
    p10 = x_i[1] * y_i[0];
    p11 = x_i[1] * y_i[1];
    z_d[0] = p00 + (p01 + rnd_i);
    z_d[1] = p11 + (p10 - rnd_i);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || zeroize) begin
      z_q <= '0;
    end else begin
      z_q <= z_d;
    end
  end

  // Output is bit-major: z_o[bit][share].
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      for (int s = 0; s < 2; s++) begin
        z_o[i][s] = z_q[s][i];
      end
    end
  end

endmodule

// File: rtl/abr_rr_arb.sv
// Round-robin one-hot arbiter; the pointer moves past the winner only when
// the grant is actually consumed.
module abr_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     grant_id
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = IDW'((int'(ptr_q) + off) % NUM_REQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        found      = 1'b1;
      end else begin
        found = found;
      end
    end
    if (advance && found) begin
      ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/abr_masked_mult_sched.sv
// Shares one masked multiplier between NUM_REQ requesters; every issue needs a
// fresh random word and the result is steered back by a tag riding alongside.
module abr_masked_mult_sched
  import abr_masked_mult_sched_pkg::*;
#(
  parameter int WIDTH   = 24,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              zeroize,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0][1:0][WIDTH-1:0] req_x_i,
  input  logic [NUM_REQ-1:0][1:0][WIDTH-1:0] req_y_i,
  input  logic                              rnd_valid_i,
  input  logic [WIDTH-1:0]                  rnd_i,
  output logic                              rnd_ready_o,
  output logic [NUM_REQ-1:0]                resp_valid_o,
  output logic [1:0][WIDTH-1:0]             resp_z_o,
  output logic                              busy_o,
  output logic [15:0]                       issue_cnt_o
);

  logic                  issue;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       gnt_id;
  logic [1:0][WIDTH-1:0] mul_x, mul_y;
  logic [WIDTH-1:0]      mul_rnd;
  logic [1:0]            mul_z [WIDTH-1:0];
  tag_t                  tag_q, tag_d;
  logic [15:0]           cnt_q, cnt_d;

  assign issue = rst_n && !zeroize && rnd_valid_i && (|req_valid_i);

  abr_rr_arb #(.NUM_REQ(NUM_REQ), .IDW(ID_W)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (zeroize),
    .req      (req_valid_i),
    .advance  (issue),
    .grant    (grant),
    .grant_id (gnt_id)
  );

  // Idle cycles feed zeros so shares of different operations never mix.
  always_comb begin
    if (issue) begin
      mul_x       = req_x_i[gnt_id];
      mul_y       = req_y_i[gnt_id];
      mul_rnd     = rnd_i;
      req_ready_o = grant;
    end else begin
      mul_x       = '0;
      mul_y       = '0;
      mul_rnd     = '0;
      req_ready_o = '0;
    end
    rnd_ready_o = issue;
    tag_d.vld   = issue;
    tag_d.id    = issue ? gnt_id : '0;
    cnt_d       = (issue && (cnt_q != CNT_MAX)) ? cnt_q + 16'd1 : cnt_q;
  end

  abr_masked_N_bit_mult_two_share #(.WIDTH(WIDTH)) u_mult (
    .clk     (clk),
    .rst_n   (rst_n),
    .zeroize (zeroize),
    .x_i     (mul_x),
    .y_i     (mul_y),
    .rnd_i   (mul_rnd),
    .z_o     (mul_z)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || zeroize) begin
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end

  // A zeroize arriving while a result is in flight drops it immediately.
  always_comb begin
    resp_valid_o = '0;
    resp_z_o     = '0;
    if (tag_q.vld && rst_n && !zeroize) begin
      resp_valid_o[tag_q.id] = 1'b1;
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < WIDTH; i++) begin
          resp_z_o[s][i] = mul_z[i][s];
        end
      end
    end else begin
      resp_valid_o = '0;
    end
  end

  assign busy_o      = tag_q.vld;
  assign issue_cnt_o = cnt_q;

endmodule

// File: doc/abr_masked_mult_sched.md
# abr_masked_mult_sched

Scheduler that shares one two-share masked N-bit multiplier (`abr_masked_N_bit_mult_two_share`, 1-cycle latency, one operation per clock) between NUM_REQ requesters.
- Arbitrates round-robin and gates every issue on fresh randomness.
- Tags each in-flight operation and routes the result back to its requester.
- Sits between the masked NTT/sampler users and the multiplier; shares are never recombined inside this block.

## Interface
Parameters:
- WIDTH, 24: operand/share width.
- NUM_REQ, 2: number of requesters (≥2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- zeroize  in  1  synchronous clear of all state.
- req_valid_i  in  NUM_REQ  per-requester operation valid.
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_x_i  in  [NUM_REQ-1:0][1:0][WIDTH-1:0]  x arithmetic shares.
- req_y_i  in  [NUM_REQ-1:0][1:0][WIDTH-1:0]  y arithmetic shares.
- rnd_valid_i  in  1  fresh randomness available.
- rnd_i  in  WIDTH  randomness word.
- rnd_ready_o  out  1  randomness consumed this cycle.
- resp_valid_o  out  NUM_REQ  one-hot result strobe.
- resp_z_o  out  [1:0][WIDTH-1:0]  product shares, shared bus.
- busy_o  out  1  operation in flight.
- issue_cnt_o  out  16  saturating count of issued operations.

## Operation
- **Issue condition:** `issue = |req_valid_i & rnd_valid_i & !zeroize`. With `rnd_valid_i` low, `req_ready_o` is all-zero and nothing issues.
- **Grant:** round-robin over valid requesters, starting at pointer `rr_ptr`. On issue to requester g, `rr_ptr <= (g+1) mod NUM_REQ`. With no issue, `rr_ptr` holds.
- **Accept:** `req_ready_o[g] = issue & grant[g]`. It is combinational from `req_valid_i`; requesters must not make valid depend on ready.
- **Randomness:** `rnd_ready_o = issue`. Each randomness word is used for exactly one operation, never reused.
- **Multiplier operands:** x/y shares of the granted requester plus `rnd_i`. When not issuing, operands and random are driven to all-zero, so idle cycles never mix shares of different operations.
- **Tagging:** a tag register captures `{issue, g}` each cycle and travels alongside the multiplier pipeline stage.
- **Result return:** the multiplier output (unpacked `[1:0] z [WIDTH-1:0]`) is repacked so that `resp_z_o[s][i] = z[i][s]`.
  - `resp_valid_o[tag_id]` is high when the tag is valid.
  - `resp_z_o` is zero when no tag is valid.
  - There is no response backpressure: consumers must accept.
- **busy_o** equals tag valid.
- **issue_cnt_o:** +1 per issue, saturates at 16'hFFFF.
- **Arithmetic:** all mod 2^WIDTH. `resp_z_o[0] + resp_z_o[1] ≡ x·y`, where x = x0+x1 and y = y0+y1.
- **zeroize:** same cycle, blocks issue. Next edge clears tag, `rr_ptr`, `issue_cnt_o` and the output registers; the multiplier's zeroize is driven by the same signal. Any in-flight result is dropped, so no `resp_valid_o` pulse follows.
- **rst_n low:** same effect as zeroize, at the next clock edge.

## Timing
- **Reset values:**
  - `resp_valid_o` = 0, `resp_z_o` = 0, `busy_o` = 0, `issue_cnt_o` = 0.
  - `rr_ptr` = 0, so requester 0 has first priority.
  - `req_ready_o` and `rnd_ready_o` are 0 while `rst_n` is low or `zeroize` is high.
- **Latency:** issue in cycle t, result (`resp_valid_o` and `resp_z_o`) in cycle t+1.
- **Throughput:** one operation per cycle; back-to-back issues give back-to-back responses.
- **Simultaneous events:**
  - All requesters valid every cycle gives strict rotation 0,1,…,NUM_REQ-1.
  - A requester that drops valid is skipped without pointer penalty.
  - A `rnd_valid_i` gap stalls all requesters; the pointer is unchanged.

## Structure
- Package `abr_masked_mult_sched_pkg`: `NUM_REQ` default, the request-id width `$clog2(NUM_REQ)`, and a tag struct `{logic vld; logic [ID_W-1:0] id;}`.
- Sub-module `abr_rr_arb`: round-robin one-hot arbiter with pointer register, parameterised on NUM_REQ, with inputs `req`, `advance` and output `grant`.
- The multiplier is instantiated once, internally.

## Test plan
Benches use WIDTH=8.
1. **Single op.** Req0: x=(3,4), y=(2,3), rnd=0x10, `rnd_valid_i`=1.
   - Next cycle: `resp_valid_o`=01 and `resp_z_o`=(31,4).
   - Sum 35 = 7·5.
2. **Contention.** Both requesters valid for 4 cycles.
   - Grants 0,1,0,1; responses alternate 01,10 one cycle later.
   - `issue_cnt_o`=4.
3. **Randomness stall.** Both valid, `rnd_valid_i` low for 3 cycles.
   - `req_ready_o`=00 and no responses during the stall.
   - On restore, the grant goes to the `rr_ptr` holder.
4. **Zeroize mid-flight.** Issue req1, then assert zeroize the next cycle.
   - No `resp_valid_o` pulse; `busy_o`=0.
   - `issue_cnt_o`=0; the next grant goes to req0.
5. **Randomized check.** 1000 random operands with random valids.
   - Every result satisfies `z0+z1 ≡ x·y mod 256`.
   - Each response id matches its issuer.
   - `rnd_ready_o` pulses exactly once per issue.
6. **Counter saturation.** Force 65540 issues; `issue_cnt_o` holds at 0xFFFF.
